ddr3_emif_arbiter: RTL and testbench

//   Shares the single DDR3 EMIF Avalon-MM port between two masters: M0 (pattern loader, writes)
//   and M1 (pattern fetcher, reads). Both masters may issue either reads or writes.

---
 rtl/ddr3_arb_pkg.sv | 34 +++
 rtl/ddr3_emif_arbiter_if.sv | 24 ++
 rtl/ddr3_arb_rsp_fifo.sv | 51 +++++
 rtl/ddr3_arb_sva.sv | 28 ++
 rtl/ddr3_emif_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_ddr3_emif_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/ddr3_arb_pkg.sv
// Shared widths, FSM encoding and response-tag layout for the DDR3 EMIF arbiter.
package ddr3_arb_pkg;

  localparam int ADDR_W    = 25;
  localparam int DATA_W    = 256;
  localparam int BE_W      = 32;
  localparam int BURST_W   = 5;
  localparam int RSP_DEPTH = 8;
  localparam int RSP_PTR_W = $clog2(RSP_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CMD    = 2'd1,
    WBURST = 2'd2
  } fsm_t;

  // One outstanding read command: who issued it and how many beats come back.
  typedef struct packed {
    logic               id;
    logic [BURST_W-1:0] burstcount;
  } tag_t;

  // A zero burst length is illegal; treat it as a single beat so the logic never stalls.
  function automatic logic [BURST_W-1:0] burst_norm(input logic [BURST_W-1:0] bc);
    logic [BURST_W-1:0] r;
    if (bc == {BURST_W{1'b0}}) begin
      r = {{(BURST_W-1){1'b0}}, 1'b1};
    end else begin
      r = bc;
    end
    return r;
  endfunction

endpackage

// File: rtl/ddr3_emif_arbiter_if.sv
// Avalon-MM style master port: one instance per datapath master.
interface ddr3_emif_arbiter_if;

  logic                               read;
  logic                               write;
  logic [ddr3_arb_pkg::ADDR_W-1:0]    addr;
  logic [ddr3_arb_pkg::BURST_W-1:0]   burstcount;
  logic [ddr3_arb_pkg::DATA_W-1:0]    writedata;
  logic [ddr3_arb_pkg::BE_W-1:0]      byteenable;
  logic                               waitrequest;
  logic [ddr3_arb_pkg::DATA_W-1:0]    readdata;
  logic                               readdatavalid;

  modport master (
    output read, write, addr, burstcount, writedata, byteenable,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  read, write, addr, burstcount, writedata, byteenable,
    output waitrequest, readdata, readdatavalid
  );

endinterface

// File: rtl/ddr3_arb_rsp_fifo.sv
// In-order FIFO of read-response tags; push and pop may happen in the same cycle.
module ddr3_arb_rsp_fifo
  import ddr3_arb_pkg::*;
(
  input  logic mem_clk,
  input  logic mem_rst_n,
  input  logic push,
  input  tag_t push_tag,
  input  logic pop,
  output tag_t head_tag,
  output logic full,
  output logic empty
);

  tag_t                 mem_r [RSP_DEPTH];
  logic [RSP_PTR_W:0]   wr_ptr_r;
  logic [RSP_PTR_W:0]   rd_ptr_r;
  logic                 do_push_s;
  logic                 do_pop_s;

  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // Tag storage; contents are only meaningful between the pointers, so no reset is needed.
  always_ff @(posedge mem_clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r[RSP_PTR_W-1:0]] <= push_tag;
    end
  end

  // Read/write pointers with a wrap bit to tell full from empty.
  always_ff @(posedge mem_clk or negedge mem_rst_n) begin
    if (!mem_rst_n) begin
      wr_ptr_r <= {(RSP_PTR_W+1){1'b0}};
      rd_ptr_r <= {(RSP_PTR_W+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + {{RSP_PTR_W{1'b0}}, 1'b1};
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{RSP_PTR_W{1'b0}}, 1'b1};
      end
    end
  end

  assign empty    = (wr_ptr_r == rd_ptr_r);
  assign full     = (wr_ptr_r[RSP_PTR_W] != rd_ptr_r[RSP_PTR_W]) &&
                    (wr_ptr_r[RSP_PTR_W-1:0] == rd_ptr_r[RSP_PTR_W-1:0]);
  assign head_tag = mem_r[rd_ptr_r[RSP_PTR_W-1:0]];

endmodule

// File: rtl/ddr3_arb_sva.sv
// Protocol checker for the EMIF arbiter; instantiated alongside the design in simulation.
module ddr3_arb_sva
  import ddr3_arb_pkg::*;
(
  input logic               mem_clk,
  input logic               mem_rst_n,
  input logic               ddr3_emif_read,
  input logic               ddr3_emif_write,
  input logic [BURST_W-1:0] ddr3_emif_burst_count,
  input logic               m0_read,
  input logic               m0_write,
  input logic               m1_read,
  input logic               m1_write
);

  // A command must never carry a zero burst length.
  a_bc_nonzero: assert property (@(posedge mem_clk) disable iff (!mem_rst_n)
    (ddr3_emif_read || ddr3_emif_write) |-> (ddr3_emif_burst_count != {BURST_W{1'b0}}))
    else $error("zero burstcount on EMIF command");

  // A master never requests a read and a write at once.
  a_m0_excl: assert property (@(posedge mem_clk) disable iff (!mem_rst_n)
    !(m0_read && m0_write)) else $error("m0 read and write together");

  a_m1_excl: assert property (@(posedge mem_clk) disable iff (!mem_rst_n)
    !(m1_read && m1_write)) else $error("m1 read and write together");

endmodule

// File: rtl/ddr3_emif_arbiter.sv
// Two-master round-robin arbiter in front of the DDR3 EMIF Avalon-MM port.
// The grant is held for a whole command; read data is steered back by an in-order tag FIFO.
module ddr3_emif_arbiter
  import ddr3_arb_pkg::*;
(
  input  logic               mem_clk,
  input  logic               mem_rst_n,
  ddr3_emif_arbiter_if.slave m0,
  ddr3_emif_arbiter_if.slave m1,
  input  logic               ddr3_emif_ready,
  input  logic [DATA_W-1:0]  ddr3_emif_read_data,
  input  logic               ddr3_emif_rddata_valid,
  output logic               ddr3_emif_read,
  output logic               ddr3_emif_write,
  output logic [ADDR_W-1:0]  ddr3_emif_addr,
  output logic [DATA_W-1:0]  ddr3_emif_write_data,
  output logic [BE_W-1:0]    ddr3_emif_byte_enable,
  output logic [BURST_W-1:0] ddr3_emif_burst_count,
  output logic               rsp_orphan
);

  fsm_t               state_r;
  logic               grant_r;
  logic               last_grant_r;
  logic [BURST_W-1:0] beat_cnt_r;
  logic [BURST_W-1:0] head_cnt_r;
  logic               orphan_r;

  logic               elig0_s;
  logic               elig1_s;
  logic               g_read_s;
  logic               g_write_s;
  logic [ADDR_W-1:0]  g_addr_s;
  logic [BURST_W-1:0] g_bc_s;
  logic [BURST_W-1:0] g_bc_norm_s;
  logic [DATA_W-1:0]  g_wd_s;
  logic [BE_W-1:0]    g_be_s;
  logic               accept_s;
  logic               push_s;
  logic               pop_s;
  tag_t               push_tag_s;
  tag_t               head_tag_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;

  // Reads need a free tag slot; writes are always eligible.
  assign elig0_s = m0.write || (m0.read && !fifo_full_s);
  assign elig1_s = m1.write || (m1.read && !fifo_full_s);

  // Select the granted master's command fields.
  always_comb begin
    g_read_s  = 1'b0;
    g_write_s = 1'b0;
    g_addr_s  = {ADDR_W{1'b0}};
    g_bc_s    = {BURST_W{1'b0}};
    g_wd_s    = {DATA_W{1'b0}};
    g_be_s    = {BE_W{1'b0}};
    if (grant_r) begin
      g_read_s  = m1.read;
      g_write_s = m1.write;
      g_addr_s  = m1.addr;
      g_bc_s    = m1.burstcount;
      g_wd_s    = m1.writedata;
      g_be_s    = m1.byteenable;
    end else begin
      g_read_s  = m0.read;
      g_write_s = m0.write;
      g_addr_s  = m0.addr;
      g_bc_s    = m0.burstcount;
      g_wd_s    = m0.writedata;
      g_be_s    = m0.byteenable;
    end
  end

  assign g_bc_norm_s = burst_norm(g_bc_s);

  // Drive the EMIF command and the per-master stalls from the current grant.
  always_comb begin
    ddr3_emif_read        = 1'b0;
    ddr3_emif_write       = 1'b0;
    ddr3_emif_addr        = g_addr_s;
    ddr3_emif_write_data  = g_wd_s;
    ddr3_emif_byte_enable = g_be_s;
    ddr3_emif_burst_count = g_bc_s;
    accept_s              = 1'b0;
    m0.waitrequest        = 1'b1;
    m1.waitrequest        = 1'b1;
    case (state_r)
      CMD: begin
        ddr3_emif_read  = g_read_s;
        ddr3_emif_write = g_write_s;
        accept_s        = (g_read_s || g_write_s) && ddr3_emif_ready;
      end
      WBURST: begin
        ddr3_emif_write = g_write_s;
        accept_s        = g_write_s && ddr3_emif_ready;
      end
      default: begin
        accept_s = 1'b0;
      end
    endcase
    if (state_r != IDLE) begin
      if (grant_r) begin
        m1.waitrequest = !ddr3_emif_ready;
      end else begin
        m0.waitrequest = !ddr3_emif_ready;
      end
    end else begin
      m0.waitrequest = 1'b1;
      m1.waitrequest = 1'b1;
    end
  end

  // Grant FSM: pick in IDLE, issue in CMD, hold through the rest of a write burst.
  always_ff @(posedge mem_clk or negedge mem_rst_n) begin
    if (!mem_rst_n) begin
      state_r      <= IDLE;
      grant_r      <= 1'b0;
      last_grant_r <= 1'b1;
      beat_cnt_r   <= {BURST_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (elig0_s || elig1_s) begin
            state_r <= CMD;
            if (elig0_s && elig1_s) begin
              grant_r <= !last_grant_r;
            end else begin
              grant_r <= elig1_s;
            end
          end
        end
        CMD: begin
          if (accept_s) begin
            last_grant_r <= grant_r;
            if (g_write_s && (g_bc_norm_s > {{(BURST_W-1){1'b0}}, 1'b1})) begin
              beat_cnt_r <= g_bc_norm_s - {{(BURST_W-1){1'b0}}, 1'b1};
              state_r    <= WBURST;
            end else begin
              state_r <= IDLE;
            end
          end
        end
        WBURST: begin
          if (accept_s) begin
            beat_cnt_r <= beat_cnt_r - {{(BURST_W-1){1'b0}}, 1'b1};
            if (beat_cnt_r <= {{(BURST_W-1){1'b0}}, 1'b1}) begin
              state_r <= IDLE;
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign push_s           = (state_r == CMD) && accept_s && g_read_s;
  assign push_tag_s.id    = grant_r;
  assign push_tag_s.burstcount = g_bc_norm_s;
  assign pop_s            = ddr3_emif_rddata_valid && !fifo_empty_s &&
                            (head_cnt_r == (head_tag_s.burstcount - {{(BURST_W-1){1'b0}}, 1'b1}));

  ddr3_arb_rsp_fifo u_rsp_fifo (
    .mem_clk   (mem_clk),
    .mem_rst_n (mem_rst_n),
    .push      (push_s),
    .push_tag  (push_tag_s),
    .pop       (pop_s),
    .head_tag  (head_tag_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  // Count beats of the head read and remember any beat that arrived with nothing outstanding.
  always_ff @(posedge mem_clk or negedge mem_rst_n) begin
    if (!mem_rst_n) begin
      head_cnt_r <= {BURST_W{1'b0}};
      orphan_r   <= 1'b0;
    end else if (ddr3_emif_rddata_valid) begin
      if (fifo_empty_s) begin
        orphan_r <= 1'b1;
      end else if (pop_s) begin
        head_cnt_r <= {BURST_W{1'b0}};
      end else begin
        head_cnt_r <= head_cnt_r + {{(BURST_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Steer each returning beat to the issuer recorded at the FIFO head.
  always_comb begin
    m0.readdatavalid = 1'b0;
    m1.readdatavalid = 1'b0;
    if (ddr3_emif_rddata_valid && !fifo_empty_s) begin
      if (head_tag_s.id) begin
        m1.readdatavalid = 1'b1;
      end else begin
        m0.readdatavalid = 1'b1;
      end
    end else begin
      m0.readdatavalid = 1'b0;
      m1.readdatavalid = 1'b0;
    end
  end

  assign m0.readdata = ddr3_emif_read_data;
  assign m1.readdata = ddr3_emif_read_data;
  assign rsp_orphan  = orphan_r;

endmodule

// File: tb/tb_ddr3_emif_arbiter.sv
// Directed bench for ddr3_emif_arbiter: a cycle table for arbitration/routing plus
// hand sequences for long bursts, tag-FIFO full and reset in mid-burst.
module tb_ddr3_emif_arbiter;
  import ddr3_arb_pkg::*;

  localparam logic [ADDR_W-1:0] A0 = 25'h00000AA;
  localparam logic [ADDR_W-1:0] A1 = 25'h0000100;

  logic               mem_clk = 1'b0;
  logic               mem_rst_n;
  logic               emif_ready;
  logic [DATA_W-1:0]  emif_rdata;
  logic               emif_rvalid;
  logic               emif_rd;
  logic               emif_wr;
  logic [ADDR_W-1:0]  emif_addr;
  logic [DATA_W-1:0]  emif_wdata;
  logic [BE_W-1:0]    emif_be;
  logic [BURST_W-1:0] emif_bc;
  logic               rsp_orphan;

  int checks   = 0;
  int failures = 0;

  ddr3_emif_arbiter_if m0_bus ();
  ddr3_emif_arbiter_if m1_bus ();

  always #5 mem_clk = ~mem_clk;

  ddr3_emif_arbiter dut (
    .mem_clk                (mem_clk),
    .mem_rst_n              (mem_rst_n),
    .m0                     (m0_bus),
    .m1                     (m1_bus),
    .ddr3_emif_ready        (emif_ready),
    .ddr3_emif_read_data    (emif_rdata),
    .ddr3_emif_rddata_valid (emif_rvalid),
    .ddr3_emif_read         (emif_rd),
    .ddr3_emif_write        (emif_wr),
    .ddr3_emif_addr         (emif_addr),
    .ddr3_emif_write_data   (emif_wdata),
    .ddr3_emif_byte_enable  (emif_be),
    .ddr3_emif_burst_count  (emif_bc),
    .rsp_orphan             (rsp_orphan)
  );

  ddr3_arb_sva u_sva (
    .mem_clk               (mem_clk),
    .mem_rst_n             (mem_rst_n),
    .ddr3_emif_read        (emif_rd),
    .ddr3_emif_write       (emif_wr),
    .ddr3_emif_burst_count (emif_bc),
    .m0_read               (m0_bus.read),
    .m0_write              (m0_bus.write),
    .m1_read               (m1_bus.read),
    .m1_write              (m1_bus.write)
  );

  typedef struct {
    logic [3:0]         req;   // {m0_rd, m0_wr, m1_rd, m1_wr}
    logic [BURST_W-1:0] bc0;
    logic [BURST_W-1:0] bc1;
    logic               rvalid;
    logic [1:0]         erw;   // expected {emif_read, emif_write}
    logic [ADDR_W-1:0]  eaddr;
    logic [BURST_W-1:0] ebc;
    logic [3:0]         wv;    // expected {m0_wait, m1_wait, m0_rdv, m1_rdv}
  } vec_t;

  vec_t vq[$];

  function automatic vec_t v(input logic [3:0] req, input logic [BURST_W-1:0] bc0,
                             input logic [BURST_W-1:0] bc1, input logic rvalid,
                             input logic [1:0] erw, input logic [ADDR_W-1:0] eaddr,
                             input logic [BURST_W-1:0] ebc, input logic [3:0] wv);
    vec_t r;
    r.req = req; r.bc0 = bc0; r.bc1 = bc1; r.rvalid = rvalid;
    r.erw = erw; r.eaddr = eaddr; r.ebc = ebc; r.wv = wv;
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] beat_pat(input int k);
    logic [31:0] w;
    w = 32'hBEEF_0000 + 32'(k);
    return {8{w}};
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    m0_bus.read = 1'b0; m0_bus.write = 1'b0; m0_bus.addr = A0;
    m0_bus.burstcount = 5'd1; m0_bus.writedata = beat_pat(0); m0_bus.byteenable = {BE_W{1'b1}};
    m1_bus.read = 1'b0; m1_bus.write = 1'b0; m1_bus.addr = A1;
    m1_bus.burstcount = 5'd1; m1_bus.writedata = beat_pat(500); m1_bus.byteenable = {BE_W{1'b1}};
    emif_ready = 1'b1; emif_rvalid = 1'b0; emif_rdata = {DATA_W{1'b0}};
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_emif_read"},  256'(emif_rd), 256'(1'b0));
    chk({tag, "_emif_write"}, 256'(emif_wr), 256'(1'b0));
    chk({tag, "_m0_wait"},    256'(m0_bus.waitrequest), 256'(1'b1));
    chk({tag, "_m1_wait"},    256'(m1_bus.waitrequest), 256'(1'b1));
    chk({tag, "_m0_rdv"},     256'(m0_bus.readdatavalid), 256'(1'b0));
    chk({tag, "_m1_rdv"},     256'(m1_bus.readdatavalid), 256'(1'b0));
    chk({tag, "_orphan"},     256'(rsp_orphan), 256'(1'b0));
  endtask

  task automatic do_reset();
    @(negedge mem_clk);
    mem_rst_n = 1'b0;
    idle_inputs();
    @(negedge mem_clk);
    #1;
    mem_rst_n = 1'b1;
  endtask

  int m0_beats, m1_acc, m0_at_m1, acc, stall_bad, m0_done, rel;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Test 1: M1 read of 4 beats.
    vq.push_back(v(4'b0010, 5'd1, 5'd4, 1'b0, 2'b00, A1, 5'd4, 4'b1100));
    vq.push_back(v(4'b0010, 5'd1, 5'd4, 1'b0, 2'b10, A1, 5'd4, 4'b1000));
    vq.push_back(v(4'b0000, 5'd1, 5'd4, 1'b1, 2'b00, A1, 5'd4, 4'b1101));
    vq.push_back(v(4'b0000, 5'd1, 5'd4, 1'b1, 2'b00, A1, 5'd4, 4'b1101));
    vq.push_back(v(4'b0000, 5'd1, 5'd4, 1'b1, 2'b00, A1, 5'd4, 4'b1101));
    vq.push_back(v(4'b0000, 5'd1, 5'd4, 1'b1, 2'b00, A1, 5'd4, 4'b1101));
    vq.push_back(v(4'b0000, 5'd1, 5'd4, 1'b0, 2'b00, A1, 5'd4, 4'b1100));
    // Test 2: both masters write continuously; state is back to reset-equivalent here.
    for (int k = 0; k < 2; k++) begin
      vq.push_back(v(4'b0101, 5'd1, 5'd1, 1'b0, 2'b00, A0, 5'd1, 4'b1100));
      vq.push_back(v(4'b0101, 5'd1, 5'd1, 1'b0, 2'b01, A0, 5'd1, 4'b0100));
      vq.push_back(v(4'b0101, 5'd1, 5'd1, 1'b0, 2'b00, A1, 5'd1, 4'b1100));
      vq.push_back(v(4'b0101, 5'd1, 5'd1, 1'b0, 2'b01, A1, 5'd1, 4'b1000));
    end
    // Test 5: M0 read burst 1 then M1 read burst 3, returns routed in order.
    vq.push_back(v(4'b1000, 5'd1, 5'd3, 1'b0, 2'b00, A0, 5'd1, 4'b1100));
    vq.push_back(v(4'b1000, 5'd1, 5'd3, 1'b0, 2'b10, A0, 5'd1, 4'b0100));
    vq.push_back(v(4'b0010, 5'd1, 5'd3, 1'b0, 2'b00, A1, 5'd3, 4'b1100));
    vq.push_back(v(4'b0010, 5'd1, 5'd3, 1'b0, 2'b10, A1, 5'd3, 4'b1000));
    vq.push_back(v(4'b0000, 5'd1, 5'd3, 1'b1, 2'b00, A1, 5'd3, 4'b1110));
    vq.push_back(v(4'b0000, 5'd1, 5'd3, 1'b1, 2'b00, A1, 5'd3, 4'b1101));
    vq.push_back(v(4'b0000, 5'd1, 5'd3, 1'b1, 2'b00, A1, 5'd3, 4'b1101));
    vq.push_back(v(4'b0000, 5'd1, 5'd3, 1'b1, 2'b00, A1, 5'd3, 4'b1101));
    vq.push_back(v(4'b0000, 5'd1, 5'd3, 1'b0, 2'b00, A1, 5'd3, 4'b1100));

    // Reset values.
    mem_rst_n = 1'b0;
    idle_inputs();
    @(negedge mem_clk);
    @(negedge mem_clk);
    #1;
    chk_reset_vals("reset");
    mem_rst_n = 1'b1;

    // Table walk.
    foreach (vq[i]) begin
      @(negedge mem_clk);
      {m0_bus.read, m0_bus.write, m1_bus.read, m1_bus.write} = vq[i].req;
      m0_bus.burstcount = vq[i].bc0;
      m1_bus.burstcount = vq[i].bc1;
      emif_rvalid = vq[i].rvalid;
      emif_rdata  = beat_pat(100 + i);
      #1;
      chk($sformatf("vec%0d_emif_read", i),  256'(emif_rd), 256'(vq[i].erw[1]));
      chk($sformatf("vec%0d_emif_write", i), 256'(emif_wr), 256'(vq[i].erw[0]));
      if (vq[i].erw != 2'b00) begin
        chk($sformatf("vec%0d_emif_addr", i), 256'(emif_addr), 256'(vq[i].eaddr));
        chk($sformatf("vec%0d_emif_bc", i),   256'(emif_bc),   256'(vq[i].ebc));
      end
      chk($sformatf("vec%0d_m0_wait", i), 256'(m0_bus.waitrequest),   256'(vq[i].wv[3]));
      chk($sformatf("vec%0d_m1_wait", i), 256'(m1_bus.waitrequest),   256'(vq[i].wv[2]));
      chk($sformatf("vec%0d_m0_rdv", i),  256'(m0_bus.readdatavalid), 256'(vq[i].wv[1]));
      chk($sformatf("vec%0d_m1_rdv", i),  256'(m1_bus.readdatavalid), 256'(vq[i].wv[0]));
      if (vq[i].rvalid) begin
        chk($sformatf("vec%0d_m0_rdata", i), m0_bus.readdata, beat_pat(100 + i));
        chk($sformatf("vec%0d_m1_rdata", i), m1_bus.readdata, beat_pat(100 + i));
      end
    end
    @(negedge mem_clk);
    {m0_bus.read, m0_bus.write, m1_bus.read, m1_bus.write} = 4'b0000;
    emif_rvalid = 1'b0;
    #1;
    chk("table_no_orphan", 256'(rsp_orphan), 256'(1'b0));

    // Test 3: M0 write burst of 8 with ready toggling, M1 read pending.
    do_reset();
    m0_bus.burstcount = 5'd8;
    m1_bus.burstcount = 5'd1;
    m0_beats = 0; m1_acc = 0; m0_at_m1 = -1;
    for (int cyc = 0; cyc < 80 && !(m0_beats == 8 && m1_acc == 1); cyc++) begin
      @(negedge mem_clk);
      emif_ready       = (cyc % 2 == 0);
      m0_bus.write     = (m0_beats < 8);
      m0_bus.writedata = beat_pat(m0_beats);
      m1_bus.read      = (m1_acc == 0);
      #1;
      if (m0_bus.write && !m0_bus.waitrequest) begin
        chk($sformatf("t3_beat%0d_strobe", m0_beats), 256'(emif_wr), 256'(1'b1));
        chk($sformatf("t3_beat%0d_data", m0_beats), emif_wdata, beat_pat(m0_beats));
        m0_beats++;
      end
      if (m1_bus.read && !m1_bus.waitrequest) begin
        chk("t3_m1_rd_strobe", 256'(emif_rd), 256'(1'b1));
        chk("t3_m1_rd_addr", 256'(emif_addr), 256'(A1));
        m0_at_m1 = m0_beats;
        m1_acc++;
      end
    end
    chk("t3_m0_beats", 256'(m0_beats), 256'(8));
    chk("t3_m1_after_burst", 256'(m0_at_m1), 256'(8));

    // Test 4: eight M1 reads of burst 2 fill the tag FIFO; the ninth stalls.
    do_reset();
    m1_bus.burstcount = 5'd2;
    acc = 0;
    for (int cyc = 0; cyc < 40 && acc < 8; cyc++) begin
      @(negedge mem_clk);
      m1_bus.read = 1'b1;
      #1;
      if (!m1_bus.waitrequest) acc++;
    end
    chk("t4_eight_reads", 256'(acc), 256'(8));
    stall_bad = 0; m0_done = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge mem_clk);
      m0_bus.write = (m0_done == 0);
      #1;
      if (!m1_bus.waitrequest) stall_bad++;
      if (m0_bus.write && !m0_bus.waitrequest) begin
        chk("t4_m0_wr_strobe", 256'(emif_wr), 256'(1'b1));
        chk("t4_m0_wr_addr", 256'(emif_addr), 256'(A0));
        m0_done = 1;
      end
    end
    chk("t4_m1_stalled", 256'(stall_bad), 256'(0));
    chk("t4_m0_write_done", 256'(m0_done), 256'(1));
    for (int b = 0; b < 2; b++) begin
      @(negedge mem_clk);
      m0_bus.write = 1'b0;
      emif_rvalid  = 1'b1;
      #1;
      chk($sformatf("t4_ret%0d_m1_rdv", b), 256'(m1_bus.readdatavalid), 256'(1'b1));
      chk($sformatf("t4_ret%0d_m0_rdv", b), 256'(m0_bus.readdatavalid), 256'(1'b0));
    end
    rel = -1;
    for (int cyc = 0; cyc < 10 && rel < 0; cyc++) begin
      @(negedge mem_clk);
      emif_rvalid = 1'b0;
      #1;
      if (!m1_bus.waitrequest) rel = cyc;
    end
    chk("t4_stall_released", 256'(rel), 256'(1));

    // Test 6: reset during beat 3 of an 8-beat write with a read outstanding.
    do_reset();
    m1_bus.burstcount = 5'd4;
    acc = 0;
    for (int cyc = 0; cyc < 10 && acc == 0; cyc++) begin
      @(negedge mem_clk);
      m1_bus.read = 1'b1;
      #1;
      if (!m1_bus.waitrequest) acc = 1;
    end
    chk("t6_read_issued", 256'(acc), 256'(1));
    m0_bus.burstcount = 5'd8;
    m0_beats = 0;
    for (int cyc = 0; cyc < 20 && m0_beats < 2; cyc++) begin
      @(negedge mem_clk);
      m1_bus.read      = 1'b0;
      m0_bus.write     = 1'b1;
      m0_bus.writedata = beat_pat(m0_beats);
      #1;
      if (!m0_bus.waitrequest) m0_beats++;
    end
    @(negedge mem_clk);
    m0_bus.writedata = beat_pat(2);
    #1;
    chk("t6_beat3_in_flight", 256'(emif_wr), 256'(1'b1));
    mem_rst_n = 1'b0;
    #1;
    chk_reset_vals("t6_rst");
    @(negedge mem_clk);
    idle_inputs();
    mem_rst_n = 1'b1;
    @(negedge mem_clk);
    emif_rvalid = 1'b1;
    #1;
    chk("t6_stray_m0_rdv", 256'(m0_bus.readdatavalid), 256'(1'b0));
    chk("t6_stray_m1_rdv", 256'(m1_bus.readdatavalid), 256'(1'b0));
    chk("t6_orphan_before", 256'(rsp_orphan), 256'(1'b0));
    @(negedge mem_clk);
    emif_rvalid = 1'b0;
    #1;
    chk("t6_orphan_set", 256'(rsp_orphan), 256'(1'b1));
    @(negedge mem_clk);
    #1;
    chk("t6_orphan_sticky", 256'(rsp_orphan), 256'(1'b1));
    chk("t6_no_write", 256'(emif_wr), 256'(1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
